// File: rtl/poly_decompress_ctrl_pkg.sv
// Shared constants and FSM encoding for the polynomial decompress controller.
package poly_decompress_ctrl_pkg;

    localparam int          KYBER_Q      = 3329;
    localparam int          DECOMP_SHIFT = 3;
    localparam int unsigned LANES        = 8;
    localparam int          LANE_W       = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/poly_decompress_ctrl_decomp3_lanes.sv
// Eight-lane 3-bit decompression: each byte's low 3 bits -> round(x * q / 8), 12 bits.
module decomp3_lanes #(
    parameter int KYBER_Q = poly_decompress_ctrl_pkg::KYBER_Q
) (
    input  logic [63:0] words_in,
    output logic [95:0] lanes_out
);
    import poly_decompress_ctrl_pkg::LANES;
    import poly_decompress_ctrl_pkg::LANE_W;
    import poly_decompress_ctrl_pkg::DECOMP_SHIFT;

    logic [31:0] prod;
    // Upper five bits of every byte are don't-care for 3-bit coefficients.
    logic [39:0] unused_bits;

    always_comb begin
        lanes_out   = '0;
        prod        = '0;
        unused_bits = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            prod = 32'(words_in[8*i +: 3]) * 32'(KYBER_Q) + 32'd4;
            lanes_out[LANE_W*i +: LANE_W] = LANE_W'(prod >> DECOMP_SHIFT);
            unused_bits[5*i +: 5] = words_in[8*i+3 +: 5];
        end
    end

endmodule

// File: rtl/poly_decompress_ctrl.sv
// Streams N_WORDS source words through read / data / decompress stages into a
// backpressured sink; a stalled write freezes the whole pipeline.
module poly_decompress_ctrl #(
    parameter int KYBER_Q = poly_decompress_ctrl_pkg::KYBER_Q,
    parameter int N_WORDS = 32,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    output logic          busy,
    output logic          done,
    output logic          src_en,
    output logic [AW-1:0] src_addr,
    input  logic [63:0]   src_rdata,
    output logic          dst_we,
    output logic [AW-1:0] dst_addr,
    output logic [95:0]   dst_wdata,
    input  logic          dst_ready
);
    import poly_decompress_ctrl_pkg::state_t;
    import poly_decompress_ctrl_pkg::S_IDLE;
    import poly_decompress_ctrl_pkg::S_RUN;
    import poly_decompress_ctrl_pkg::S_DRAIN;
    import poly_decompress_ctrl_pkg::S_DONE;

    localparam int CW = $clog2(N_WORDS + 1);

    state_t        state;
    logic          rd_v;
    logic          data_v;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic          stall;
    logic          adv;
    logic          wr_fire;
    logic [95:0]   lanes;

    assign stall   = dst_we & ~dst_ready;
    assign adv     = ~stall;
    assign wr_fire = dst_we & dst_ready;
    // A pending read is withheld during a stall so the memory keeps the
    // previous word on src_rdata until the data stage can advance.
    assign src_en  = rd_v & adv;

    decomp3_lanes #(
        .KYBER_Q (KYBER_Q)
    ) u_lanes (
        .words_in  (src_rdata),
        .lanes_out (lanes)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_v      <= 1'b0;
            data_v    <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            src_addr  <= '0;
            dst_we    <= 1'b0;
            dst_addr  <= '0;
            dst_wdata <= '0;
        end else begin
            done <= 1'b0;

            if (wr_fire) begin
                wr_cnt   <= wr_cnt + 1'b1;
                dst_addr <= dst_addr + 1'b1;
            end

            if (adv) begin
                data_v <= rd_v;
                dst_we <= data_v;
                if (data_v) begin
                    dst_wdata <= lanes;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        rd_v     <= 1'b1;
                        rd_cnt   <= CW'(1);
                        src_addr <= src_base;
                        wr_cnt   <= '0;
                        dst_addr <= dst_base;
                    end
                end
                S_RUN: begin
                    if (adv) begin
                        if (rd_cnt == CW'(N_WORDS)) begin
                            rd_v  <= 1'b0;
                            state <= S_DRAIN;
                        end else begin
                            rd_cnt   <= rd_cnt + 1'b1;
                            src_addr <= src_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wr_fire && (wr_cnt == CW'(N_WORDS - 1))) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/poly_decompress_ctrl.md
POLY_DECOMPRESS_CTRL -- requirements
Module: poly_decompress_ctrl

Interface
REQ-001 The block SHALL have parameter KYBER_Q, default 3329, the modulus used in decompression.
REQ-002 The block SHALL have parameter N_WORDS, default 32, the number of 64-bit source words per polynomial (256 coefficients).
REQ-003 The block SHALL have parameter AW, default 8, the address width of the source and destination memories.
REQ-004 clk  input  1  The single clock; all logic is rising-edge triggered.
REQ-005 rst_n  input  1  Reset; asynchronous assert, active-low.
REQ-006 start  input  1  One-cycle request to decompress one polynomial.
REQ-007 src_base  input  AW  First source word address, sampled on an accepted start.
REQ-008 dst_base  input  AW  First destination word address, sampled on an accepted start.
REQ-009 busy  output  1  High from the cycle after an accepted start until done.
REQ-010 done  output  1  One-cycle pulse after the final write completes.
REQ-011 src_en, src_addr  output  1, AW  Source read enable and address.
REQ-012 src_rdata  input  64  Source read data, valid one cycle after src_en; the memory holds it while src_en is low.
REQ-013 dst_we, dst_addr, dst_wdata  output  1, AW, 96  Destination write strobe, address and data.
REQ-014 dst_ready  input  1  Sink acceptance; a write completes in a cycle where dst_we and dst_ready are both high.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE -> RUN SHALL occur on start; start outside IDLE SHALL be ignored.
REQ-017 RUN -> DRAIN SHALL occur after N_WORDS reads have been issued.
REQ-018 DRAIN -> DONE SHALL occur when the N_WORDS-th write completes; DONE -> IDLE SHALL occur after one cycle.
REQ-019 Read k SHALL drive src_en=1 and src_addr=src_base+k, for k = 0..N_WORDS-1, modulo 2^AW.
REQ-020 The pipeline SHALL have three stages: read issue, read data, decompress register. Each stage SHALL carry a valid bit.
REQ-021 Write k SHALL drive dst_addr=dst_base+k (modulo 2^AW) and dst_wdata equal to the decompressed word k.
REQ-022 For each lane i = 0..7, dst_wdata[12i+11:12i] SHALL equal ((src_rdata[8i+7:8i] & 7) * KYBER_Q + 4) >> 3, computed at 16-bit or wider width and truncated to 12 bits; the maximum value is 2913.
REQ-023 Timing without stalls: start sampled at edge 0 -> read k in cycle 1+k, write k in cycle 3+k, last write in cycle 34, done=1 and busy=0 in cycle 35.
REQ-024 Stall: while dst_we=1 and dst_ready=0, every pipeline stage, the counters and dst_* SHALL hold and src_en SHALL be 0; no word is dropped or duplicated.
REQ-025 Exactly N_WORDS writes SHALL occur per start; dst_we SHALL be 0 outside RUN and DRAIN.
REQ-026 src_en SHALL never be asserted for k >= N_WORDS.
REQ-027 A start arriving in the same cycle as done SHALL be ignored.
REQ-028 If dst_ready stays low indefinitely, the block SHALL hold with busy=1 and no timeout.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state IDLE and busy, done, src_en and dst_we to 0.
REQ-030 Reset SHALL clear src_addr, dst_addr, dst_wdata, the counters and the valid bits to 0.
REQ-031 Reset mid-operation SHALL abandon the transfer with no further writes and no done pulse.
REQ-032 After reset release, the first accepted start SHALL behave exactly as in REQ-023.

Structure
REQ-033 A shared package SHALL hold KYBER_Q, the 3-bit decompress shift, the lane count (8), the lane width (12) and the FSM state encoding.
REQ-034 The combinational 8-lane arithmetic SHALL be the sub-module decomp3_lanes (64-bit in, 96-bit out); the controller SHALL own the stage registers and their hold enable.

Verification
REQ-035 Basic run: src words all 0x0706050403020100, dst_ready=1 -> 32 writes at cycles 3..34, each lane i = {0,416,832,1248,1665,2081,2497,2913}[i], done in cycle 35.
REQ-036 Masking and addressing: src word 0xFFFFFFFFFFFFFFFF -> every lane 2913; src_base=0xF0 -> read addresses wrap 0xF0..0xFF,0x00..0x0F; dst_base=0x20 -> write addresses 0x20..0x3F.
REQ-037 Backpressure: dst_ready low for 5 cycles at write 10 -> write 10 held stable, src_en=0 during the stall, all 32 words in order, done in cycle 40.
REQ-038 Random backpressure: 50% random dst_ready over 1000 runs -> write data matches the REQ-022 model and exactly 32 writes per start.
REQ-039 Start interactions: start pulsed while busy and in the done cycle -> ignored; back-to-back starts after IDLE -> two full independent runs.
REQ-040 Reset mid-run: rst_n low at write 12 -> outputs 0 immediately, no done; a subsequent start yields a clean 32-write run.
